mont_exp_ctrl: RTL

MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

---
 rtl/mont_exp_ctrl_pkg.sv | 28 ++
 rtl/mont_exp_ctrl_if.sv | 24 ++
 rtl/mont_exp_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mont_exp_ctrl_pkg.sv
// Shared definitions for the Montgomery modular-exponentiation controller:
// default operand width, FSM encoding and the per-operation multiplier call count.
package mont_exp_ctrl_pkg;

    localparam int MONT_N = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOMONT,
        ST_SQUARE,
        ST_MULT,
        ST_FROMMONT,
        ST_DONE
    } state_e;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_e;

    // One call to enter the Montgomery domain plus one to leave it.
    localparam int MM_FIXED_CALLS = 2;

    function automatic int mm_call_count(input int n, input int ones);
        return n + ones + MM_FIXED_CALLS;
    endfunction

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Request/response bus between the exponentiation controller and the
// Montgomery multiplier.
interface mont_exp_ctrl_if #(
    parameter int N = mont_exp_ctrl_pkg::MONT_N
) ();

    logic         mm_start;
    logic [N-1:0] mm_a;
    logic [N-1:0] mm_b;
    logic [N-1:0] mm_m;
    logic [N-1:0] mm_result;
    logic         mm_done;

    modport master (
        output mm_start, mm_a, mm_b, mm_m,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_start, mm_a, mm_b, mm_m,
        output mm_result, mm_done
    );

endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply controller computing X^E mod M through an
// external Montgomery multiplier; operands are presented as muxes of held registers.
module mont_exp_ctrl
    import mont_exp_ctrl_pkg::*;
#(
    parameter int N = MONT_N
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [N-1:0]   in_x,
    input  logic [N-1:0]   in_e,
    input  logic [N-1:0]   in_m,
    input  logic [N-1:0]   in_r,
    input  logic [N-1:0]   in_r2,
    output logic [N-1:0]   result,
    output logic           done,
    output logic           busy,
    mont_exp_ctrl_if.master mm
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [N-1:0]  x_q, e_q, m_q, r2_q, a_q, xm_q;
    logic [IW-1:0] i_q;
    logic          in_mm;
    logic          accept;
    logic          mm_fire;
    logic          last_bit;

    assign in_mm    = state_q inside {ST_TOMONT, ST_SQUARE, ST_MULT, ST_FROMMONT};
    assign accept   = (state_q == ST_IDLE) && start;
    assign mm_fire  = in_mm && (phase_q == PH_WAIT) && mm.mm_done;
    assign last_bit = (i_q == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            phase_q <= PH_ISSUE;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_TOMONT;
                    phase_d = PH_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                phase_d = PH_ISSUE;
            end
            default: begin
                if (phase_q == PH_ISSUE) begin
                    phase_d = PH_WAIT;
                end else if (mm.mm_done) begin
                    phase_d = PH_ISSUE;
                    // The bit index is tested before any decrement so it never wraps.
                    case (state_q)
                        ST_TOMONT: state_d = ST_SQUARE;
                        ST_SQUARE: state_d = e_q[i_q] ? ST_MULT
                                           : (last_bit ? ST_FROMMONT : ST_SQUARE);
                        ST_MULT:   state_d = last_bit ? ST_FROMMONT : ST_SQUARE;
                        default:   state_d = ST_DONE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        mm.mm_a = '0;
        mm.mm_b = '0;
        case (state_q)
            ST_TOMONT: begin
                mm.mm_a = x_q;
                mm.mm_b = r2_q;
            end
            ST_SQUARE: begin
                mm.mm_a = a_q;
                mm.mm_b = a_q;
            end
            ST_MULT: begin
                mm.mm_a = a_q;
                mm.mm_b = xm_q;
            end
            ST_FROMMONT: begin
                mm.mm_a = a_q;
                mm.mm_b = N'(1);
            end
            default: ;
        endcase
    end

    assign mm.mm_m     = m_q;
    assign mm.mm_start = in_mm && (phase_q == PH_ISSUE);
    assign done        = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q    <= '0;
            e_q    <= '0;
            m_q    <= '0;
            r2_q   <= '0;
            a_q    <= '0;
            xm_q   <= '0;
            i_q    <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                x_q  <= in_x;
                e_q  <= in_e;
                m_q  <= in_m;
                r2_q <= in_r2;
                a_q  <= in_r;
                i_q  <= IW'(N - 1);
            end
            if (mm_fire) begin
                case (state_q)
                    ST_TOMONT: xm_q <= mm.mm_result;
                    ST_SQUARE: begin
                        a_q <= mm.mm_result;
                        if (!e_q[i_q] && !last_bit) i_q <= i_q - 1'b1;
                    end
                    ST_MULT: begin
                        a_q <= mm.mm_result;
                        if (!last_bit) i_q <= i_q - 1'b1;
                    end
                    default: result <= mm.mm_result;
                endcase
            end
        end
    end

endmodule
